// File: rtl/clock_base_top.sv
// UART (8N1) receiver feeding a DEPTH-stage byte shift register, with an
// LED register that shows either the newest or the oldest stored byte.
module clock_base_top #(
    parameter int unsigned CLKS_PER_BIT = 1736,
    parameter int unsigned DEPTH        = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       sw,
    input  logic       ct_UartRx,
    output logic [7:0] ct_Led
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic [7:0]       stage [DEPTH];

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= ct_UartRx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // Receiver: mid-bit sampling, byte_valid pulses only on a good stop bit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt    <= '0;
                        byte_valid <= rx_s;
                        state      <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    // Byte shift register; the oldest byte falls off the end.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= 8'h00;
            end
        end else if (byte_valid) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                stage[k] <= stage[k-1];
            end
            stage[0] <= rx_byte;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ct_Led <= 8'h00;
        end else begin
            ct_Led <= sw ? stage[DEPTH-1] : stage[0];
        end
    end

endmodule

// File: tb/tb_clock_base_top.sv
// Bench for clock_base_top: drives serial frames at a shortened bit time and
// compares the LED display against a byte-history model.
module tb_clock_base_top;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic       CLK = 1'b0;
    logic       reset;
    logic       sw;
    logic       rx;
    logic [7:0] led;

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         skip_early = 1'b0;
    logic [7:0] hist [$];

    always #5 CLK = ~CLK;

    clock_base_top #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .sw       (sw),
        .ct_UartRx(rx),
        .ct_Led   (led)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_new();
        return (hist.size() > 0) ? hist[hist.size()-1] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_old();
        return (hist.size() >= DEPTH) ? hist[hist.size()-DEPTH] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_shown();
        return sw ? exp_old() : exp_new();
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_bits(input int n);
        wait_cycles(n * CPB);
    endtask

    task automatic set_sw(input logic v);
        @(negedge CLK);
        sw = v;
        @(negedge CLK);
    endtask

    task automatic check_both(input string tag);
        set_sw(1'b0);
        chk({tag, "_new"}, led, exp_new());
        set_sw(1'b1);
        chk({tag, "_old"}, led, exp_old());
    endtask

    // One 8N1 frame; the line is left at the stop level so a framing error
    // can be stretched by the caller.
    task automatic send(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        if (!skip_early) chk("before_stop", led, exp_shown());
        rx = stop_ok;
        wait_bits(1);
        if (stop_ok) hist.push_back(b);
        chk(stop_ok ? "frame" : "framing_err", led, exp_shown());
    endtask

    initial begin
        logic [7:0] burst1 [6];
        logic [7:0] burst2 [6];
        logic [7:0] b;
        burst1 = '{8'hF4, 8'h7E, 8'h03, 8'h55, 8'h57, 8'h41};
        burst2 = '{8'h7E, 8'h04, 8'hC0, 8'hF0, 8'hFC, 8'hFF};

        reset = 1'b1;
        sw    = 1'b0;
        rx    = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        check_both("reset");
        wait_bits(3);
        check_both("idle");

        set_sw(1'b0);
        send(8'hF4, 1'b1);
        chk("single_lit", led, 8'hF4);
        wait_bits(1);

        foreach (burst1[i]) begin
            send(burst1[i], 1'b1);
            rx = 1'b1;
            wait_cycles(10);
        end
        check_both("burst1");
        set_sw(1'b1);
        chk("burst1_lit_old", led, 8'h03);

        rx = 1'b1;
        wait_bits(5);
        set_sw(1'b0);
        foreach (burst2[i]) begin
            send(burst2[i], 1'b1);
            rx = 1'b1;
        end
        chk("burst2_lit_new", led, 8'hFF);
        check_both("burst2");

        // Framing error with the line held low afterwards.
        set_sw(1'b0);
        send(8'h55, 1'b0);
        wait_bits(3);
        chk("held_low", led, exp_new());
        rx = 1'b1;
        wait_bits(2);
        check_both("after_ferr");
        set_sw(1'b0);
        send(8'hAA, 1'b1);
        rx = 1'b1;
        wait_bits(1);
        check_both("aa");

        // Short low pulse must be rejected at the start-bit sample.
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_bits(3);
        check_both("glitch");

        // Randomized frames, gaps from zero to two bit times, some bad stops.
        set_sw(1'b0);
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                send(b, 1'b0);
                wait_bits(1);
                rx = 1'b1;
                wait_bits(1);
            end else begin
                send(b, 1'b1);
                rx = 1'b1;
            end
            wait_cycles($urandom_range(0, 2 * CPB));
        end
        check_both("random");

        // sw toggle takes effect one cycle later.
        @(negedge CLK);
        sw = 1'b0;
        @(negedge CLK);
        chk("sw_to0", led, exp_new());
        sw = 1'b1;
        @(negedge CLK);
        chk("sw_to1", led, exp_old());

        // One-cycle reset during the data bits of 0x33.
        set_sw(1'b0);
        b = 8'h33;
        rx = 1'b0;
        wait_bits(1);
        rx = b[0];
        wait_cycles(CPB / 2);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        hist.delete();
        wait_cycles(CPB / 2 - 1);
        for (int i = 1; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = 1'b1;
        wait_bits(1);
        chk("reset_mid", led, 8'h00);
        // The tail of 0x33 may be taken as a new frame; wait it out.
        wait_bits(12);
        skip_early = 1'b1;
        send(8'h0F, 1'b1);
        skip_early = 1'b0;
        rx = 1'b1;
        chk("after_rst_lit", led, 8'h0F);
        for (int n = 0; n < DEPTH - 1; n++) begin
            send(8'($urandom_range(0, 255)), 1'b1);
            rx = 1'b1;
        end
        set_sw(1'b1);
        chk("flush_old", led, 8'h0F);
        check_both("flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_base_top.md
# clock_base_top

UART-fed byte shift register with LED display, the top level of the board-bring-up design. It receives 8N1 serial bytes on `ct_UartRx` at 57600 baud from a 100 MHz clock and shifts each valid byte into a 4-stage byte shift register. `ct_Led` shows either the newest byte or the oldest stage, selected by `sw`.

## Interface
- `CLKS_PER_BIT`, default 1736: clock cycles per UART bit (100 MHz / 57600).
- `DEPTH`, default 4: number of byte stages in the shift register (minimum 2).
- `CLK` in, 1 bit: system clock, 100 MHz. One clock, and it is the only clock.
- `reset` in, 1 bit: synchronous, active-high reset.
- `sw` in, 1 bit: display select. 0 shows stage 0 (newest byte); 1 shows stage DEPTH-1 (oldest byte).
- `ct_UartRx` in, 1 bit: asynchronous serial input, idle high.
- `ct_Led` out, 8 bits: registered display output.

## Operation
- **Input synchronizer:** `ct_UartRx` passes through a 2-flop synchronizer. The synchronizer flops reset to 1 (idle). All receiver logic uses the synchronized signal `rx_s`.
- **Receiver FSM states:** IDLE, START, DATA, STOP.
  - IDLE: a falling edge of `rx_s` (previous 1, current 0) moves to START and clears the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles (868), then sample. If `rx_s`=0, go to DATA. If `rx_s`=1, it is a glitch: go to IDLE, no byte.
  - DATA: sample once every CLKS_PER_BIT cycles, 8 samples, LSB first, into shift register `rx_byte`. After the 8th sample, go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample. If `rx_s`=1, assert a one-cycle `byte_valid` and return to IDLE. If `rx_s`=0 (framing error), discard the byte and go to IDLE; IDLE still requires a falling edge, so a held-low line produces no bytes.
- **Shift register:** on `byte_valid`, stage[k] <= stage[k-1] for k = DEPTH-1 down to 1, and stage[0] <= `rx_byte`. Stages hold their values otherwise. The shift register does not wrap: the oldest byte is dropped.
- **Display:** every cycle, `ct_Led` <= (`sw` ? stage[DEPTH-1] : stage[0]). `sw` is treated as static; it is not synchronized beyond this register.
- **Counter widths:** the baud counter is sized to hold CLKS_PER_BIT-1. The bit counter is 3 bits.

## Timing
- **Reset:** on reset, FSM goes to IDLE, all stages are 0x00, `ct_Led` is 0x00, `rx_byte` is 0x00, synchronizer flops are 1, and counters are 0. Reset overrides everything on the same edge.
- **Reset mid-frame:** the partial byte is discarded and the shift register is cleared. The receiver restarts only on the next falling edge after reset deasserts.
- **Sample points:** a sample is taken at 868 + n×1736 cycles after the start edge is detected on `rx_s` (n = 1..8 for data, n = 9 for stop). The synchronizer adds 2 cycles of input latency.
- **Output latency:** `byte_valid` is asserted on the cycle of the stop sample. Stages update on the next edge, and `ct_Led` follows one edge later. Total: `ct_Led` changes 2 cycles after the stop-bit sample.
- **Back-to-back frames:** a new start edge arriving immediately after the stop sample (half a bit period later, or any later time) must be received. Minimum inter-frame gap is 0 extra bits.
- **`sw` toggling:** `ct_Led` reflects the new selection one cycle after `sw` changes.

## Test plan
- **Reset:** reset=1 for 2+ cycles, then 0 → `ct_Led`=0x00 for both `sw` values; no activity while `ct_Rx`=1.
- **Single byte:** send 0xF4 (bit time 17360 ns), `sw`=0 → `ct_Led`=0xF4 within 30 ns after the stop-bit midpoint.
- **Six-byte burst:** send 0xF4, 0x7E, 0x03, 0x55, 0x57, 0x41 with 100 ns gaps → `sw`=0 gives `ct_Led`=0x41; `sw`=1 gives 0x03.
- **Second burst:** after 600 µs idle, send 0x7E, 0x04, 0xC0, 0xF0, 0xFC, 0xFF → `sw`=0 gives 0xFF; `sw`=1 gives 0xC0.
- **Framing error:** send 0x55 with the stop bit held 0, then release the line high → all stages unchanged; the next valid 0xAA is then received correctly.
- **Glitch and reset mid-frame:** a low pulse of 4000 ns produces no byte. Asserting reset for one cycle during the data bits of 0x33 → `ct_Led`=0x00, and the following 0x0F is received correctly.
